// File: rtl/fir_decim_serial.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_rom
// Description : Coefficient ROM with a registered output (one cycle of read
//               latency). The table is selected by coef_sel:
//                  0 : unit impulse at tap 0 (pass-through filter)
//                  1 : every tap = 1.0
//                  2 : 0.5 at tap 0
//                  3 : 1.0 at the last tap (pure delay of taps-1 samples)
//                  4 : 0.5 at tap 0, -0.25 at tap 200, 1.0 at the last tap
//               Addresses at or beyond taps read as zero.
// Ports       : clk  - clock
//               addr - tap index
//               data - signed coefficient, fp_bits fraction bits
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_rom #(
   parameter int addr_bits = 9,
   parameter int rom_bits  = 24,
   parameter int fp_bits   = 22,
   parameter int taps      = 496,
   parameter int coef_sel  = 0
) (
   input  logic                       clk,
   input  logic [addr_bits-1:0]       addr,
   output logic signed [rom_bits-1:0] data
);

   localparam logic signed [rom_bits-1:0] c_one     = rom_bits'(1) <<< fp_bits;
   localparam logic signed [rom_bits-1:0] c_half    = c_one >>> 1;
   localparam logic signed [rom_bits-1:0] c_quarter = c_one >>> 2;
   localparam logic [addr_bits-1:0]       c_last    = addr_bits'(taps - 1);
   localparam logic [addr_bits-1:0]       c_mid     = addr_bits'(200);

   function automatic logic signed [rom_bits-1:0] coef_at(input logic [addr_bits-1:0] a);
      logic signed [rom_bits-1:0] c;
      c = '0;
      if (a <= c_last) begin
         case (coef_sel)
            0:       if (a == '0) c = c_one;
            1:       c = c_one;
            2:       if (a == '0) c = c_half;
            3:       if (a == c_last) c = c_one;
            default: begin
               if (a == '0)          c = c_half;
               else if (a == c_mid)  c = -c_quarter;
               else if (a == c_last) c = c_one;
            end
         endcase
      end
      return c;
   endfunction

   always_ff @(posedge clk) begin
      data <= coef_at(addr);
   end

endmodule

// ============================================================================
// Module      : fir_decim_serial
// Description : Decimating FIR filter built around a single multiply-
//               accumulate unit. Samples enter a 2^addr_bits circular history
//               buffer; every decim-th accepted sample starts a pass over
//               taps history entries (newest first) against the coefficient
//               ROM. The rounded, saturated result appears exactly 500 cycles
//               after the triggering sample with a one-cycle rdy strobe.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous reset, active low
//               wren   - sample valid strobe
//               sample - signed input sample
//               out    - signed filtered result, held between results
//               rdy    - one-cycle strobe, out updated this cycle
//               ovf    - sticky: a trigger arrived while a pass was running
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_serial #(
   parameter int bits      = 16,
   parameter int rom_bits  = 24,
   parameter int fp_bits   = 22,
   parameter int taps      = 496,
   parameter int addr_bits = 9,
   parameter int decim     = 8,
   parameter int coef_sel  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wren,
   input  logic signed [bits-1:0] sample,
   output logic signed [bits-1:0] out,
   output logic                   rdy,
   output logic                   ovf
);

   localparam int acc_bits = addr_bits + bits + rom_bits;
   localparam int c_ph_w   = (decim > 1) ? $clog2(decim) : 1;
   localparam int c_prod_w = bits + rom_bits;

   localparam logic [c_ph_w-1:0]          c_ph_last    = c_ph_w'(decim - 1);
   localparam logic [addr_bits-1:0]       c_addr_last  = '1;
   localparam logic [addr_bits-1:0]       c_k_last     = addr_bits'(taps - 1);
   // Three drain cycles: buffer/ROM read, product register, accumulate.
   localparam logic [addr_bits-1:0]       c_flush_last = addr_bits'(2);
   localparam logic signed [acc_bits-1:0] c_round      = acc_bits'(1) <<< (fp_bits - 1);
   localparam logic signed [acc_bits-1:0] c_max        = (acc_bits'(1) <<< (bits - 1)) - acc_bits'(1);
   localparam logic signed [acc_bits-1:0] c_min        = -(acc_bits'(1) <<< (bits - 1));

   typedef enum logic [2:0] {
      S_CLR   = 3'd0,
      S_IDLE  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                       state_q;
   logic [addr_bits-1:0]         wp_q;
   logic [addr_bits-1:0]         newest_q;
   logic [addr_bits-1:0]         k_q;
   logic [c_ph_w-1:0]            ph_q;
   logic signed [bits-1:0]       hist_q [0:(1<<addr_bits)-1];
   logic signed [bits-1:0]       rdat_q;
   logic                         rv_q;
   logic                         pv_q;
   logic signed [c_prod_w-1:0]   prod_q;
   logic signed [acc_bits-1:0]   acc_q;
   logic signed [bits-1:0]       out_q;
   logic                         rdy_q;
   logic                         ovf_q;

   logic signed [rom_bits-1:0]   w_coef;
   logic                         w_accept;
   logic                         w_trigger;
   logic                         w_we;
   logic signed [bits-1:0]       w_wdata;
   logic [addr_bits-1:0]         w_raddr;
   logic signed [acc_bits-1:0]   w_rnd;
   logic signed [bits-1:0]       out_d;

   fir_coef_rom #(
      .addr_bits (addr_bits),
      .rom_bits  (rom_bits),
      .fp_bits   (fp_bits),
      .taps      (taps),
      .coef_sel  (coef_sel)
   ) u_rom (
      .clk  (clk),
      .addr (k_q),
      .data (w_coef)
   );

   // Samples are refused only while the buffer is being zeroed.
   assign w_accept  = wren && (state_q != S_CLR);
   assign w_trigger = w_accept && (ph_q == c_ph_last);
   assign w_we      = rst && ((state_q == S_CLR) || w_accept);
   assign w_wdata   = (state_q == S_CLR) ? '0 : sample;
   // Walk backwards from the newest sample; 9-bit arithmetic wraps naturally.
   assign w_raddr   = newest_q - k_q;
   assign w_rnd     = (acc_q + c_round) >>> fp_bits;

   always_comb begin
      out_d = w_rnd[bits-1:0];
      if (w_rnd > c_max)      out_d = {1'b0, {(bits-1){1'b1}}};
      else if (w_rnd < c_min) out_d = {1'b1, {(bits-1){1'b0}}};
   end

   // History buffer: one write port (new sample or clear), one registered read.
   always_ff @(posedge clk) begin
      if (w_we) hist_q[wp_q] <= w_wdata;
      rdat_q <= hist_q[w_raddr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_CLR;
         wp_q     <= '0;
         ph_q     <= '0;
         newest_q <= '0;
         k_q      <= '0;
         rv_q     <= 1'b0;
         pv_q     <= 1'b0;
         prod_q   <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         rdy_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rdy_q  <= 1'b0;
         rv_q   <= (state_q == S_RUN);
         pv_q   <= rv_q;
         prod_q <= c_prod_w'(rdat_q) * c_prod_w'(w_coef);
         if (pv_q) acc_q <= acc_q + acc_bits'(prod_q);

         if (w_accept) begin
            wp_q <= wp_q + addr_bits'(1);
            ph_q <= w_trigger ? '0 : ph_q + c_ph_w'(1);
         end
         // A trigger outside IDLE is dropped; the running pass continues.
         if (w_trigger && (state_q != S_IDLE)) ovf_q <= 1'b1;

         case (state_q)
            S_CLR: begin
               // wp doubles as the clear address and ends back at zero.
               wp_q <= wp_q + addr_bits'(1);
               if (wp_q == c_addr_last) state_q <= S_IDLE;
            end
            S_IDLE: begin
               if (w_trigger) begin
                  newest_q <= wp_q;
                  k_q      <= '0;
                  acc_q    <= '0;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               if (k_q == c_k_last) begin
                  k_q     <= '0;
                  state_q <= S_FLUSH;
               end else begin
                  k_q <= k_q + addr_bits'(1);
               end
            end
            S_FLUSH: begin
               if (k_q == c_flush_last) begin
                  out_q   <= out_d;
                  rdy_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q + addr_bits'(1);
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_CLR;
         endcase
      end
   end

   assign out = out_q;
   assign rdy = rdy_q;
   assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_serial
// Description : Self-checking bench for fir_decim_serial using coefficient
//               table 4 (0.5 at tap 0, -0.25 at tap 200, 1.0 at tap 495).
//               A reference model keeps every accepted sample since reset and
//               computes each expected result as a plain convolution; rdy,
//               out and ovf are compared every cycle, plus directed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_serial;

   logic               clk;
   logic               rst;
   logic               wren;
   logic signed [15:0] sample;
   logic signed [15:0] dut_out;
   logic               rdy;
   logic               ovf;

   fir_decim_serial #(
      .coef_sel (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wren   (wren),
      .sample (sample),
      .out    (dut_out),
      .rdy    (rdy),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int                 cyc;
   int                 clr_left;
   int                 ph;
   int                 busy_end;
   int                 hist[$];
   int                 due_q[$];
   logic signed [15:0] val_q[$];
   logic               m_rdy;
   logic               m_ovf;
   logic signed [15:0] m_out;

   function automatic longint coef_ref(input int k);
      if (k == 0)   return longint'(1) <<< 21;
      if (k == 200) return -(longint'(1) <<< 20);
      if (k == 495) return longint'(1) <<< 22;
      return 0;
   endfunction

   // Filter output for a window ending at the newest accepted sample.
   function automatic logic signed [15:0] ref_out();
      longint acc;
      longint r;
      int     n;
      acc = 0;
      n   = hist.size() - 1;
      for (int k = 0; k < 496; k++)
         if (n - k >= 0) acc += longint'(hist[n-k]) * coef_ref(k);
      r = (acc + (longint'(1) <<< 21)) >>> 22;
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model across the edge,
   // then compare all outputs at the falling edge.
   task automatic tick(input logic r, input logic w, input int s);
      rst    = r;
      wren   = w;
      sample = 16'(s);
      @(posedge clk);
      if (!r) begin
         clr_left = 512;
         ph       = 0;
         busy_end = -1;
         hist.delete();
         due_q.delete();
         val_q.delete();
         m_ovf    = 1'b0;
         m_out    = '0;
      end else if (clr_left > 0) begin
         clr_left--;
      end else if (w) begin
         hist.push_back(s);
         if (ph == 7) begin
            if (cyc <= busy_end) begin
               m_ovf = 1'b1;
            end else begin
               busy_end = cyc + 500;
               due_q.push_back(cyc + 500);
               val_q.push_back(ref_out());
            end
            ph = 0;
         end else begin
            ph++;
         end
      end
      cyc++;
      m_rdy = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         m_rdy = 1'b1;
         m_out = val_q[0];
         void'(due_q.pop_front());
         void'(val_q.pop_front());
      end
      @(negedge clk);
      checks++;
      assert (rdy === m_rdy) else begin
         errors++;
         $error("FAIL rdy cyc=%0d observed=%0b expected=%0b", cyc, rdy, m_rdy);
      end
      checks++;
      assert (dut_out === m_out) else begin
         errors++;
         $error("FAIL out cyc=%0d observed=%0d expected=%0d", cyc, dut_out, m_out);
      end
      checks++;
      assert (ovf === m_ovf) else begin
         errors++;
         $error("FAIL ovf cyc=%0d observed=%0b expected=%0b", cyc, ovf, m_ovf);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b1, 1'b0, 0);
   endtask

   task automatic feed(input int v, input int spacing);
      tick(1'b1, 1'b1, v);
      if (spacing > 1) idle(spacing - 1);
   endtask

   // Run until the model has no result outstanding (bounded).
   task automatic wait_due();
      int guard;
      guard = 0;
      while (due_q.size() > 0 && guard < 700) begin
         tick(1'b1, 1'b0, 0);
         guard++;
      end
   endtask

   task automatic rand_wren(input int n);
      logic signed [15:0] r16;
      repeat (n) begin
         r16 = 16'($urandom);
         tick(1'b1, 1'($urandom), int'(r16));
      end
   endtask

   initial begin
      logic signed [15:0] r16;
      cyc      = 0;
      clr_left = 0;
      ph       = 0;
      busy_end = -1;
      m_rdy    = 1'b0;
      m_ovf    = 1'b0;
      m_out    = '0;
      rst      = 1'b0;
      wren     = 1'b0;
      sample   = '0;

      // Reset, then the clear sweep with wren toggling (ignored).
      repeat (3) tick(1'b0, 1'b0, 0);
      chk("reset_out", dut_out, 16'sd0);
      chk("reset_ovf", 16'(ovf), 16'sd0);
      chk("reset_rdy", 16'(rdy), 16'sd0);
      rand_wren(512);
      idle(4);

      // Round half up: 0.5 * 3 -> 2, 0.5 * -3 -> -1.
      repeat (7) feed(0, 64);
      feed(3, 64);
      wait_due();
      chk("round_pos", dut_out, 16'sd2);
      repeat (7) feed(0, 64);
      feed(-3, 64);
      wait_due();
      chk("round_neg", dut_out, -16'sd1);

      // Random full-scale samples at the nominal rate.
      repeat (32) begin
         r16 = 16'($urandom);
         feed(int'(r16), 64);
      end
      wait_due();
      chk("rand_ovf_clear", 16'(ovf), 16'sd0);

      // Back-to-back burst: second trigger lands mid-pass and is dropped.
      repeat (16) begin
         r16 = 16'($urandom);
         feed(int'(r16), 1);
      end
      wait_due();
      idle(20);
      chk("burst_ovf", 16'(ovf), 16'sd1);

      // Positive and negative saturation with a full window of extremes.
      repeat (496) feed(32767, 32);
      idle(520);
      repeat (8) feed(32767, 32);
      wait_due();
      chk("sat_pos", dut_out, 16'sd32767);
      repeat (496) feed(-32768, 32);
      idle(520);
      repeat (8) feed(-32768, 32);
      wait_due();
      chk("sat_neg", dut_out, -16'sd32768);
      chk("ovf_sticky", 16'(ovf), 16'sd1);

      // Ramp crossing several write-pointer wraps.
      for (int i = 0; i < 1024; i++) feed(i, 32);
      wait_due();

      // Reset 200 cycles into a pass: no result, history zeroed.
      repeat (7) feed(1000, 32);
      tick(1'b1, 1'b1, 1000);
      idle(199);
      tick(1'b0, 1'b0, 0);
      chk("abort_out", dut_out, 16'sd0);
      chk("abort_ovf", 16'(ovf), 16'sd0);
      rand_wren(512);
      idle(4);
      repeat (8) begin
         r16 = 16'($urandom);
         feed(int'(r16), 64);
      end
      wait_due();
      chk("post_reset_ovf", 16'(ovf), 16'sd0);
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
